blake2_msg_feeder: RTL
======================

// Module: blake2_msg_feeder
// PURPOSE
// Host-side transmitter for the blake2 core byte interface. Accepts a hash command and a host
// byte stream, buffers one message block, and zero-pads the final block. Drives the core's
// indexed byte port with first/last flags and total length, then returns the digest bytes
// with the lead beat stripped. Sits between the host PIO/bus bridge and the blake2 core.
// PARAMETERS
// BLK    64  bytes per block; core_idx_o width IW=$clog2(BLK)
// NW     7   width of kk/nn fields; matches core $clog2(W+1)
// LL_W   64  message byte counter width; zero-extended by integrator to the core's ll width
// PORTS
// clk          in   1     clock
// nreset       in   1     reset: synchronous, active-low
// cmd_v_i      in   1     command valid; accepted when cmd_v_i & cmd_rdy_o
// cmd_rdy_o    out  1     high only in S_IDLE
// cmd_kk_i     in   NW    key length, latched on cmd accept
// cmd_nn_i     in   NW    digest length 1..(W/8), latched on cmd accept
// cmd_empty_i  in   1     message has zero bytes; skip fill
// in_v_i       in   1     host byte valid
// in_rdy_o     out  1     high only in S_FILL
// in_data_i    in   8     host byte
// in_last_i    in   1     marks final message byte
// core_kk_o    out  NW    latched kk, held until return to S_IDLE
// core_nn_o    out  NW    latched nn, held until return to S_IDLE
// core_ll_o    out  LL_W  bytes accepted so far; stable during last-block drain
// core_first_o out  1     current drained block is message block 0
// core_last_o  out  1     current drained block is final block
// core_data_v_o out 1     byte strobe to core
// core_idx_o   out  IW    byte index in block, 0..BLK-1
// core_data_o  out  8     byte to core
// core_ready_i in   1     core ready_v (registered in core)
// core_h_v_i   in   1     core digest valid
// core_h_i     in   8     core digest byte
// dig_v_o      out  1     digest byte valid; no backpressure
// dig_o        out  8     digest byte, h[0] LSB first
// dig_last_o   out  1     with the nn-th digest byte
// busy_o       out  1     state != S_IDLE
// BEHAVIOUR
// - Reset: state S_IDLE; every output 0 except cmd_rdy_o=1; counters, flags, buffer cleared.
// - Reset mid-operation aborts all activity; the next cycle matches post-reset state.
// - Storage: BLK x 8 buffer, fill_cnt (0..BLK), idx counter (IW), byte count ll (LL_W),
//   first_q, last_q, lead_q, dig_cnt (NW).
// - S_IDLE: on cmd accept, latch kk/nn, clear ll, first_q=1, lead_q=1.
//   If cmd_empty_i=1: set last_q=1, fill_cnt=0, go to S_DRAIN. Otherwise go to S_FILL.
// - S_FILL: each in_v_i & in_rdy_o writes buf[fill_cnt], fill_cnt++, ll++ (wraps mod 2^LL_W).
//   On in_last_i: last_q=1, go to S_DRAIN.
//   On fill_cnt reaching BLK without last: last_q=0, go to S_DRAIN.
// - S_DRAIN: core_data_v_o = core_ready_i, combinational; core_data_o = (idx<fill_cnt) ? buf[idx] : 8'h00.
//   idx++ per strobe. If core_ready_i is low: no strobe, idx holds.
//   core_first_o=first_q and core_last_o=last_q are constant for all BLK bytes.
//   After the strobe at idx=BLK-1: idx=0, fill_cnt=0, first_q=0.
//   Next state is S_DIGEST if last_q, else S_FILL.
//   The next S_FILL overlaps core compression. The next drain waits on core_ready_i.
// - Key block is host data: the host sends the key zero-padded to BLK bytes; these count in ll.
// - S_DIGEST: the first core_h_v_i beat is the core's lead beat and is discarded (lead_q cleared).
//   Each following beat drives dig_v_o=1 and dig_o=core_h_i with 1-cycle latency (registered).
//   dig_cnt++ per beat. When dig_cnt==nn: dig_last_o=1, go to S_IDLE, release kk/nn.
// - in_v_i outside S_FILL and cmd_v_i outside S_IDLE are ignored (no side effects).
// - in_last_i on the BLK-th byte gives a full last block, no padding, and no extra block.
// TESTING
// - cmd_empty_i=1, nn=32, kk=0 -> 64 strobes idx 0..63, data 0, first=last=1, ll=0; 32 dig beats, lead beat dropped, dig_last on the 32nd.
// - "abc" (61,62,63) with last on 63 -> block data 61,62,63 then 61x 00; first=last=1, ll=3.
// - 64 bytes 0..63 with last on byte 63 -> one block, no padding, ll=64, no second block.
// - 65 bytes -> block0 first=1 last=0; block1 first=0 last=1, one byte + 63x 00, ll=65; block1 waits for core_ready_i.
// - core_ready_i low 5 cycles at idx=20 -> no strobes, idx holds 20, resumes at 20; total 64 strobes.
// - nreset low during drain at idx=30 -> next cycle all outputs 0, cmd_rdy_o=1, busy_o=0.

Source files
------------

// File: rtl/blake2_msg_feeder.sv
// blake2_msg_feeder: buffers host message bytes one block at a time and zero-pads the
// final block. It streams each block to the blake2 core's indexed byte port, then returns
// the digest bytes to the host with the core's lead beat removed.
module blake2_msg_feeder #(
  parameter int BLK  = 64,
  parameter int NW   = 7,
  parameter int LL_W = 64
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    cmd_v_i,
  output logic                    cmd_rdy_o,
  input  logic [NW-1:0]           cmd_kk_i,
  input  logic [NW-1:0]           cmd_nn_i,
  input  logic                    cmd_empty_i,
  input  logic                    in_v_i,
  output logic                    in_rdy_o,
  input  logic [7:0]              in_data_i,
  input  logic                    in_last_i,
  output logic [NW-1:0]           core_kk_o,
  output logic [NW-1:0]           core_nn_o,
  output logic [LL_W-1:0]         core_ll_o,
  output logic                    core_first_o,
  output logic                    core_last_o,
  output logic                    core_data_v_o,
  output logic [$clog2(BLK)-1:0]  core_idx_o,
  output logic [7:0]              core_data_o,
  input  logic                    core_ready_i,
  input  logic                    core_h_v_i,
  input  logic [7:0]              core_h_i,
  output logic                    dig_v_o,
  output logic [7:0]              dig_o,
  output logic                    dig_last_o,
  output logic                    busy_o
);

  localparam int IW = $clog2(BLK);
  localparam int CW = IW + 1;  // fill count must reach BLK itself

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DIGEST} state_t;

  state_t            state_q;
  logic [7:0]        buf_q [BLK];
  logic [CW-1:0]     fill_cnt_q;
  logic [IW-1:0]     idx_q;
  logic [LL_W-1:0]   ll_q;
  logic [NW-1:0]     kk_q;
  logic [NW-1:0]     nn_q;
  logic [NW-1:0]     dig_cnt_q;
  logic [NW-1:0]     dig_cnt_d;
  logic              first_q;
  logic              last_q;
  logic              lead_q;
  logic              dig_v_q;
  logic [7:0]        dig_q;
  logic              dig_last_q;
  logic              in_drain;
  logic              pad_byte;

  assign dig_cnt_d = dig_cnt_q + NW'(1);
  assign in_drain  = (state_q == S_DRAIN);
  // Bytes at or beyond the fill count are padding and always read as zero.
  assign pad_byte  = ({1'b0, idx_q} >= fill_cnt_q);

  // Block buffer: cleared on reset, written in order while filling.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      for (int i = 0; i < BLK; i++) buf_q[i] <= 8'h00;
    end else if (state_q == S_FILL && in_v_i) begin
      buf_q[fill_cnt_q[IW-1:0]] <= in_data_i;
    end
  end

  // Main sequencer: command latch, fill, drain to core, digest return.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      fill_cnt_q <= '0;
      idx_q      <= '0;
      ll_q       <= '0;
      kk_q       <= '0;
      nn_q       <= '0;
      dig_cnt_q  <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      lead_q     <= 1'b0;
      dig_v_q    <= 1'b0;
      dig_q      <= 8'h00;
      dig_last_q <= 1'b0;
    end else begin
      dig_v_q    <= 1'b0;
      dig_last_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_v_i) begin
            kk_q       <= cmd_kk_i;
            nn_q       <= cmd_nn_i;
            ll_q       <= '0;
            first_q    <= 1'b1;
            lead_q     <= 1'b1;
            dig_cnt_q  <= '0;
            idx_q      <= '0;
            fill_cnt_q <= '0;
            last_q     <= cmd_empty_i;
            state_q    <= cmd_empty_i ? S_DRAIN : S_FILL;
          end
        end
        S_FILL: begin
          if (in_v_i) begin
            fill_cnt_q <= fill_cnt_q + CW'(1);
            ll_q       <= ll_q + LL_W'(1);
            if (in_last_i) begin
              last_q  <= 1'b1;
              state_q <= S_DRAIN;
            end else if (fill_cnt_q == CW'(BLK - 1)) begin
              last_q  <= 1'b0;
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (core_ready_i) begin
            if (idx_q == IW'(BLK - 1)) begin
              idx_q      <= '0;
              fill_cnt_q <= '0;
              first_q    <= 1'b0;
              state_q    <= last_q ? S_DIGEST : S_FILL;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        S_DIGEST: begin
          if (core_h_v_i) begin
            if (lead_q) begin
              lead_q <= 1'b0;
            end else begin
              dig_v_q   <= 1'b1;
              dig_q     <= core_h_i;
              dig_cnt_q <= dig_cnt_d;
              if (dig_cnt_d == nn_q) begin
                dig_last_q <= 1'b1;
                kk_q       <= '0;
                nn_q       <= '0;
                last_q     <= 1'b0;
                state_q    <= S_IDLE;
              end
            end
          end
        end
      endcase
    end
  end

  assign cmd_rdy_o     = (state_q == S_IDLE);
  assign in_rdy_o      = (state_q == S_FILL);
  assign busy_o        = (state_q != S_IDLE);
  assign core_kk_o     = kk_q;
  assign core_nn_o     = nn_q;
  assign core_ll_o     = ll_q;
  assign core_first_o  = in_drain & first_q;
  assign core_last_o   = in_drain & last_q;
  assign core_data_v_o = in_drain & core_ready_i;
  assign core_idx_o    = idx_q;
  assign core_data_o   = (in_drain && !pad_byte) ? buf_q[idx_q] : 8'h00;
  assign dig_v_o       = dig_v_q;
  assign dig_o         = dig_q;
  assign dig_last_o    = dig_last_q;

endmodule
